// File: rtl/tag_sort_pkg.sv
// Shared widths, FSM state encoding and header layout for the tag-sort dequeue path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   TAG_W/SPB_AW/ID_W/DATA_W/LEN_W  default bus widths
//   RD_LAT_CYC  tag circuit request-to-result latency
//   OCC_W       occupancy counter width
//   HDR_LEN_LSB position of the length field in the header word
//   state_t     dequeue FSM states
package tag_sort_pkg;

    localparam int TAG_W       = 12;
    localparam int SPB_AW      = 13;
    localparam int ID_W        = 13;
    localparam int DATA_W      = 32;
    localparam int LEN_W       = 6;
    localparam int RD_LAT_CYC  = 2;
    localparam int OCC_W       = 13;

    // Packet length (in words, header included) sits in the low bits of the header.
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CAP,
        ST_HDR,
        ST_STREAM,
        ST_FREE
    } state_t;

endpackage

// File: rtl/tag_sort_dequeue_ctrl_skid.sv
// Two-entry output FIFO of {data,sop,eop} with registered valid and an occupancy count.
// Latency: a word pushed in cycle n is presented on o_vld in cycle n+1.
// Backpressure: head word held stable while o_vld & !i_rdy; the producer must keep pushes within the free slots (o_cnt).
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_push, i_dat, i_sop, i_eop  write side (no full check: caller guarantees space)
//   o_vld, o_dat, o_sop, o_eop   head word, i_rdy pops it
//   o_cnt                        entries currently stored (0..2)
module dq_skid_buf
    import tag_sort_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_sop,
    input  logic          i_eop,
    input  logic          i_rdy,
    output logic          o_vld,
    output logic [DW-1:0] o_dat,
    output logic          o_sop,
    output logic          o_eop,
    output logic [1:0]    o_cnt
);

    logic [DW+1:0] r_mem [0:1];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_cnt;
    logic          w_pop;

    assign w_pop = (r_cnt != 2'd0) & i_rdy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= {i_dat, i_sop, i_eop};
            end
            r_wr_ptr <= r_wr_ptr ^ i_push;
            r_rd_ptr <= r_rd_ptr ^ w_pop;
            r_cnt    <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_vld                 = (r_cnt != 2'd0);
    assign {o_dat, o_sop, o_eop} = r_mem[r_rd_ptr];
    assign o_cnt                 = r_cnt;

endmodule

// File: rtl/tag_sort_dequeue_ctrl.sv
// Dequeues the smallest-tag packet from the tag circuit, streams its SPB words out, then frees its SPB address.
// Latency: pck_addr_req to first o_out_valid is RD_LAT+2 cycles; 1 word/cycle while o_out_ready stays high.
// Backpressure: SPB reads are throttled so the 2-entry skid buffer never overflows; release waits for the eop handshake.
//
// Ports:
//   i_clk, i_rst                                  clock, asynchronous active-high reset
//   i_tag_wr, i_wr_done_mem                       tag insert pulse, tag circuit idle
//   o_pck_addr_req, i_pck_addr_out/id/tag         dequeue request and its result (RD_LAT later)
//   o_spb_rd_en/addr, i_spb_rd_data               SPB read port, data one cycle after strobe
//   o_spb_free_valid/addr                         SPB address release pulse
//   o_out_valid/i_out_ready/data/sop/eop/id/tag   packet word stream
//   o_occ, o_ovf_err                              tag occupancy, sticky overflow flag
module tag_sort_dequeue_ctrl
    import tag_sort_pkg::*;
#(
    parameter int T      = TAG_W,
    parameter int S      = SPB_AW,
    parameter int I      = ID_W,
    parameter int D      = DATA_W,
    parameter int L      = LEN_W,
    parameter int RD_LAT = RD_LAT_CYC,
    parameter int C      = OCC_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tag_wr,
    input  logic         i_wr_done_mem,
    output logic         o_pck_addr_req,
    input  logic [S-1:0] i_pck_addr_out,
    input  logic [I-1:0] i_pck_id_out,
    input  logic [T-1:0] i_tag_value_out,
    output logic         o_spb_rd_en,
    output logic [S-1:0] o_spb_rd_addr,
    input  logic [D-1:0] i_spb_rd_data,
    output logic         o_spb_free_valid,
    output logic [S-1:0] o_spb_free_addr,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [D-1:0] o_out_data,
    output logic         o_out_sop,
    output logic         o_out_eop,
    output logic [I-1:0] o_out_id,
    output logic [T-1:0] o_out_tag,
    output logic [C-1:0] o_occ,
    output logic         o_ovf_err
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [C-1:0] r_occ;
    logic         r_ovf;
    logic [3:0]   r_wait_cnt;
    logic [S-1:0] r_base;
    logic [I-1:0] r_id;
    logic [T-1:0] r_tag;
    logic [L-1:0] r_len;
    logic [L-1:0] r_rd_idx;     // index of the next word to read (header is 0)
    logic         r_infl;       // a read was issued last cycle, its data is on i_spb_rd_data now
    logic         r_infl_eop;
    logic         r_eop_acc;    // last word of the current packet has been handed off

    logic         w_req;
    logic         w_can_req;
    logic         w_rd_en;
    logic [S-1:0] w_rd_addr;
    logic         w_rd_last;
    logic         w_free;
    logic [L-1:0] w_len_raw;
    logic [L-1:0] w_len;
    logic [S-1:0] w_body_addr;
    logic         w_push;
    logic         w_push_sop;
    logic         w_push_eop;
    logic         w_sk_vld;
    logic [D-1:0] w_sk_dat;
    logic         w_sk_sop;
    logic         w_sk_eop;
    logic [1:0]   w_sk_cnt;
    logic         w_pop;
    logic [2:0]   w_fill;
    logic         w_space;

    assign w_req     = (r_state == ST_REQ);
    assign w_can_req = (r_occ != '0) & i_wr_done_mem & ~i_tag_wr;

    // A zero length field still carries the header, so it is a one-word packet.
    assign w_len_raw = i_spb_rd_data[HDR_LEN_LSB +: L];
    assign w_len     = (w_len_raw == '0) ? L'(1) : w_len_raw;

    // Modulo-2^S address: the sum simply wraps from 2^S-1 to 0.
    assign w_body_addr = r_base + S'(r_rd_idx);

    // Word arriving from the SPB this cycle; the header's eop is only known once its length is visible.
    assign w_push     = r_infl;
    assign w_push_sop = (r_state == ST_HDR);
    assign w_push_eop = (r_state == ST_HDR) ? (w_len == L'(1)) : r_infl_eop;

    // Fill level after this cycle's push/pop; a new read lands next cycle, so it may issue only if
    // that level leaves a slot. Counting this cycle's pop is what allows one word per cycle.
    assign w_pop   = w_sk_vld & i_out_ready;
    assign w_fill  = {1'b0, w_sk_cnt} + {2'b00, w_push} - {2'b00, w_pop};
    assign w_space = (w_fill < 3'd2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        w_rd_last   = 1'b0;
        w_free      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_can_req) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                w_state_nxt = (RD_LAT > 1) ? ST_WAIT : ST_CAP;
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'(RD_LAT - 2)) begin
                    w_state_nxt = ST_CAP;
                end
            end
            ST_CAP: begin
                // The previous packet's eop was accepted before its release, so the buffer is empty here.
                w_rd_en     = 1'b1;
                w_rd_addr   = i_pck_addr_out;
                w_state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (w_len == L'(1)) begin
                    w_state_nxt = ST_FREE;
                end else begin
                    w_state_nxt = ST_STREAM;
                    if (w_space) begin
                        w_rd_en   = 1'b1;
                        w_rd_addr = w_body_addr;
                        w_rd_last = (r_rd_idx == w_len - L'(1));
                    end
                end
            end
            ST_STREAM: begin
                if (r_rd_idx == r_len) begin
                    w_state_nxt = ST_FREE;
                end else if (w_space) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = w_body_addr;
                    w_rd_last = (r_rd_idx == r_len - L'(1));
                end
            end
            ST_FREE: begin
                if (r_eop_acc) begin
                    w_free      = 1'b1;
                    w_state_nxt = w_can_req ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Occupancy: a write and a dequeue in the same cycle cancel out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_occ <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (i_tag_wr && (r_occ == {C{1'b1}})) begin
                r_ovf <= 1'b1;
            end
            case ({i_tag_wr, w_req})
                2'b10: begin
                    if (r_occ != {C{1'b1}}) begin
                        r_occ <= r_occ + C'(1);
                    end
                end
                2'b01: begin
                    r_occ <= r_occ - C'(1);
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait_cnt <= '0;
            r_base     <= '0;
            r_id       <= '0;
            r_tag      <= '0;
            r_len      <= '0;
            r_rd_idx   <= '0;
            r_infl     <= 1'b0;
            r_infl_eop <= 1'b0;
            r_eop_acc  <= 1'b0;
        end else begin
            if (r_state == ST_REQ) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            if (r_state == ST_CAP) begin
                r_base    <= i_pck_addr_out;
                r_id      <= i_pck_id_out;
                r_tag     <= i_tag_value_out;
                r_rd_idx  <= L'(1);
                r_eop_acc <= 1'b0;
            end else begin
                if (w_rd_en) begin
                    r_rd_idx <= r_rd_idx + L'(1);
                end
                if (w_pop && w_sk_eop) begin
                    r_eop_acc <= 1'b1;
                end
            end

            if (r_state == ST_HDR) begin
                r_len <= w_len;
            end

            r_infl     <= w_rd_en;
            r_infl_eop <= w_rd_last;
        end
    end

    dq_skid_buf #(
        .DW (D)
    ) u_skid (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (w_push),
        .i_dat  (i_spb_rd_data),
        .i_sop  (w_push_sop),
        .i_eop  (w_push_eop),
        .i_rdy  (i_out_ready),
        .o_vld  (w_sk_vld),
        .o_dat  (w_sk_dat),
        .o_sop  (w_sk_sop),
        .o_eop  (w_sk_eop),
        .o_cnt  (w_sk_cnt)
    );

    assign o_pck_addr_req   = w_req;
    assign o_spb_rd_en      = w_rd_en;
    assign o_spb_rd_addr    = w_rd_addr;
    assign o_spb_free_valid = w_free;
    assign o_spb_free_addr  = w_free ? r_base : '0;
    assign o_out_valid      = w_sk_vld;
    assign o_out_data       = w_sk_dat;
    assign o_out_sop        = w_sk_sop;
    assign o_out_eop        = w_sk_eop;
    assign o_out_id         = r_id;
    assign o_out_tag        = r_tag;
    assign o_occ            = r_occ;
    assign o_ovf_err        = r_ovf;

endmodule
